// File: rtl/alien_shot_scheduler.sv
// rtl/alien_shot_scheduler.sv - picks when and from which alien column the next enemy shot is fired
//
// Purpose:
//   Waits a frame-based cooldown and then requests a random sample from the
//   generator with a one-cycle rand_req pulse. The sample selects the column
//   where the search for a live alien starts. The cooldown that follows an
//   acknowledged shot also uses the sample. Columns are searched one per cycle.
//   The first live column is offered to the missile block with a
//   fire_req/fire_ack handshake.
//
// Ports:
//   clk             in   1          system clock
//   resetN          in   1          asynchronous, active-low reset
//   enable          in   1          game running; low forces IDLE
//   start_of_frame  in   1          one-cycle pulse per video frame
//   alive_cols      in   COLS       bit i = column i has at least one live alien
//   rand_val        in   RAND_BITS  random value latched by the generator
//   fire_ack        in   1          missile block accepted the request
//   rand_req        out  1          one-cycle pulse requesting a new random sample
//   fire_req        out  1          shot request, held until fire_ack or abort
//   fire_col        out  COL_BITS   column to fire from, stable while fire_req=1
//   shots_fired     out  16         acknowledged shots, saturating

module alien_shot_scheduler #(
  parameter int COLS       = 8,
  parameter int RAND_BITS  = 8,
  parameter int MIN_DELAY  = 30,
  parameter int DELAY_BITS = 5,
  parameter int CNT_BITS   = 8,
  localparam int COL_BITS  = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 enable,
  input  logic                 start_of_frame,
  input  logic [COLS-1:0]      alive_cols,
  input  logic [RAND_BITS-1:0] rand_val,
  input  logic                 fire_ack,
  output logic                 rand_req,
  output logic                 fire_req,
  output logic [COL_BITS-1:0]  fire_col,
  output logic [15:0]          shots_fired
);

  typedef enum logic [2:0] {
    IDLE,
    COOLDOWN,
    SAMPLE,
    WAIT_RAND,
    SCAN,
    FIRE
  } state_t;

  localparam logic [CNT_BITS-1:0] MIN_CNT  = CNT_BITS'(MIN_DELAY);
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [COL_BITS:0]   COLS_EXT = (COL_BITS + 1)'(COLS);

  state_t                state, state_d;
  logic [CNT_BITS-1:0]   cnt, cnt_d;
  logic [COL_BITS-1:0]   scan_ptr, scan_ptr_d;
  logic [COL_BITS-1:0]   scan_n, scan_n_d;
  // Only the bits that set the extra cooldown are kept from the sample.
  logic [DELAY_BITS-1:0] rnd_q, rnd_d;
  logic [COL_BITS-1:0]   fire_col_d;
  logic [15:0]           shots_d;

  // Starting column from the low sample bits, folded back into range when
  // COLS is not a power of two.
  logic [COL_BITS:0]     start_raw;
  logic [COL_BITS-1:0]   start_col;

  always_comb begin
    start_raw = {1'b0, rand_val[COL_BITS-1:0]};
    if (start_raw >= COLS_EXT) begin
      start_col = COL_BITS'(start_raw - COLS_EXT);
    end else begin
      start_col = rand_val[COL_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      cnt         <= '0;
      scan_ptr    <= '0;
      scan_n      <= '0;
      rnd_q       <= '0;
      fire_col    <= '0;
      shots_fired <= '0;
      rand_req    <= 1'b0;
      fire_req    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      scan_ptr    <= scan_ptr_d;
      scan_n      <= scan_n_d;
      rnd_q       <= rnd_d;
      fire_col    <= fire_col_d;
      shots_fired <= shots_d;
      // Strobes are registered from the next state so that they line up
      // exactly with the cycles spent in SAMPLE and FIRE.
      rand_req    <= (state_d == SAMPLE);
      fire_req    <= (state_d == FIRE);
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    scan_ptr_d = scan_ptr;
    scan_n_d   = scan_n;
    rnd_d      = rnd_q;
    fire_col_d = fire_col;
    shots_d    = shots_fired;

    case (state)
      IDLE: begin
        if (enable) begin
          state_d = COOLDOWN;
          cnt_d   = MIN_CNT;
        end
      end

      COOLDOWN: begin
        if (cnt == '0) begin
          state_d = SAMPLE;
        end else if (start_of_frame) begin
          cnt_d = cnt - 1'b1;
        end
      end

      SAMPLE: begin
        state_d = WAIT_RAND;
      end

      // The generator presents the new sample one cycle after the request.
      WAIT_RAND: begin
        rnd_d      = rand_val[RAND_BITS-1 -: DELAY_BITS];
        scan_ptr_d = start_col;
        scan_n_d   = '0;
        state_d    = SCAN;
      end

      SCAN: begin
        if (alive_cols[scan_ptr]) begin
          fire_col_d = scan_ptr;
          state_d    = FIRE;
        end else if (scan_n == LAST_COL) begin
          // Every column was empty; try again after a minimum cooldown.
          state_d  = COOLDOWN;
          cnt_d    = MIN_CNT;
          scan_n_d = '0;
        end else begin
          scan_ptr_d = (scan_ptr == LAST_COL) ? '0 : scan_ptr + 1'b1;
          scan_n_d   = scan_n + 1'b1;
        end
      end

      FIRE: begin
        // An ack in the same cycle as the column dying still counts as a shot.
        if (fire_ack) begin
          shots_d = (shots_fired == 16'hFFFF) ? shots_fired : shots_fired + 16'd1;
          state_d = COOLDOWN;
          cnt_d   = MIN_CNT + CNT_BITS'(rnd_q);
        end else if (!alive_cols[fire_col]) begin
          state_d = SAMPLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (!enable) begin
      state_d    = IDLE;
      cnt_d      = '0;
      scan_ptr_d = '0;
      scan_n_d   = '0;
    end
  end

endmodule

// File: tb/tb_alien_shot_scheduler.sv
// tb/tb_alien_shot_scheduler.sv - directed self-checking bench for alien_shot_scheduler

module tb_alien_shot_scheduler;

  logic        clk = 1'b0;
  logic        resetN;
  logic        enable;
  logic        start_of_frame;
  logic [7:0]  alive_cols;
  logic [7:0]  rand_val;
  logic        fire_ack;
  logic        rand_req;
  logic        fire_req;
  logic [2:0]  fire_col;
  logic [15:0] shots_fired;

  int n_checks = 0;
  int n_pass   = 0;
  int rr_cnt   = 0;
  int rr_dbl   = 0;
  int fr_cnt   = 0;
  logic rr_last = 1'b0;

  alien_shot_scheduler #(
    .COLS(8), .RAND_BITS(8), .MIN_DELAY(4), .DELAY_BITS(3), .CNT_BITS(8)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .enable(enable),
    .start_of_frame(start_of_frame),
    .alive_cols(alive_cols),
    .rand_val(rand_val),
    .fire_ack(fire_ack),
    .rand_req(rand_req),
    .fire_req(fire_req),
    .fire_col(fire_col),
    .shots_fired(shots_fired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_req) rr_cnt++;
    if (rand_req && rr_last) rr_dbl++;
    rr_last = rand_req;
    if (fire_req) fr_cnt++;
  endtask

  task automatic sof_pulse();
    start_of_frame = 1'b1;
    tick();
    start_of_frame = 1'b0;
    tick();
  endtask

  task automatic sof_n(input int n);
    repeat (n) sof_pulse();
  endtask

  initial begin
    int rr0;
    int fc0;
    int k;
    resetN = 1'b0; enable = 1'b0; start_of_frame = 1'b0;
    alive_cols = 8'h00; rand_val = 8'h00; fire_ack = 1'b0;
    #12;
    check("rst_rand_req", rand_req, 0);
    check("rst_fire_req", fire_req, 0);
    check("rst_fire_col", fire_col, 0);
    check("rst_shots", shots_fired, 0);
    resetN = 1'b1;

    // First shot: start column 5, all alive
    enable = 1'b1; alive_cols = 8'hFF; rand_val = 8'h05;
    tick();
    rr0 = rr_cnt;
    sof_n(3);
    check("a_no_early_req", rr_cnt, rr0);
    sof_pulse();
    check("a_rand_req", rand_req, 1);
    tick();
    check("a_req_single", rand_req, 0);
    tick();
    check("a_fire_t2", fire_req, 0);
    tick();
    check("a_fire_t3", fire_req, 1);
    check("a_fire_col", fire_col, 5);
    check("a_rr_count", rr_cnt, 1);
    tick(); tick();
    check("a_fire_held", fire_req, 1);
    fire_ack = 1'b1; tick(); fire_ack = 1'b0;
    check("a_fire_drop", fire_req, 0);
    check("a_shots", shots_fired, 1);

    // Stray ack outside FIRE, then wrap-around scan to column 2
    fire_ack = 1'b1; tick(); fire_ack = 1'b0;
    check("b_ack_ignored", shots_fired, 1);
    alive_cols = 8'b0000_0100; rand_val = 8'h06;
    sof_n(4);
    check("b_rand_req", rand_req, 1);
    k = 0;
    while (!fire_req && k < 20) begin tick(); k++; end
    check("b_latency", k, 7);
    check("b_fire_col", fire_col, 2);
    fire_ack = 1'b1; tick(); fire_ack = 1'b0;
    check("b_shots", shots_fired, 2);

    // No live column: full scan, no fire, minimum cooldown
    alive_cols = 8'h00; rand_val = 8'h00;
    sof_n(4);
    check("c_rand_req", rand_req, 1);
    fc0 = fr_cnt;
    repeat (12) tick();
    check("c_no_fire", fr_cnt, fc0);
    alive_cols = 8'hFF; rand_val = 8'hE3;
    rr0 = rr_cnt;
    sof_n(3);
    check("c_no_early_req", rr_cnt, rr0);
    sof_pulse();
    check("c_rand_req2", rand_req, 1);

    // Sample E3: column 3, extra cooldown 7
    tick(); tick(); tick();
    check("d_fire", fire_req, 1);
    check("d_fire_col", fire_col, 3);
    repeat (10) tick();
    check("d_fire_held", fire_req, 1);
    fire_ack = 1'b1; tick(); fire_ack = 1'b0;
    check("d_fire_drop", fire_req, 0);
    check("d_shots", shots_fired, 3);
    rr0 = rr_cnt; rand_val = 8'h01;
    sof_n(10);
    check("d_no_early_req", rr_cnt, rr0);
    sof_pulse();
    check("d_req_after_11", rand_req, 1);

    // Column dies while requested -> resample; then ack + death together
    tick(); tick(); tick();
    check("e_fire_col1", fire_col, 1);
    check("e_fire", fire_req, 1);
    alive_cols = 8'hFD; rand_val = 8'h02;
    tick();
    check("e_withdraw", fire_req, 0);
    check("e_resample", rand_req, 1);
    tick(); tick(); tick();
    check("e_fire2", fire_req, 1);
    check("e_fire_col2", fire_col, 2);
    check("e_shots_kept", shots_fired, 3);
    alive_cols = 8'hFB; fire_ack = 1'b1; rr0 = rr_cnt;
    tick(); fire_ack = 1'b0;
    check("e_ack_wins", shots_fired, 4);
    check("e_ack_drop", fire_req, 0);
    tick(); tick();
    check("e_no_resample", rr_cnt, rr0);

    // Drop enable during FIRE, re-enable, then reset mid-scan
    alive_cols = 8'hFF; rand_val = 8'h06;
    sof_n(4);
    check("f_rand_req", rand_req, 1);
    tick(); tick(); tick();
    check("f_fire", fire_req, 1);
    check("f_fire_col", fire_col, 6);
    enable = 1'b0; tick();
    check("f_disable_fire", fire_req, 0);
    check("f_shots_kept", shots_fired, 4);
    enable = 1'b1; tick();
    rr0 = rr_cnt;
    sof_n(3);
    check("f_reenable_wait", rr_cnt, rr0);
    sof_pulse();
    check("f_reenable_req", rand_req, 1);
    tick(); tick();
    #1 resetN = 1'b0;
    #1;
    check("g_rst_rand_req", rand_req, 0);
    check("g_rst_fire_req", fire_req, 0);
    check("g_rst_fire_col", fire_col, 0);
    check("g_rst_shots", shots_fired, 0);
    resetN = 1'b1;
    tick();

    check("rand_req_never_double", rr_dbl, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
